// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel comma aligner.
//   state_t       : aligner states HUNT / ALIGN / ACTIVE
//   COMMA_DEFAULT : default alignment/idle comma byte (K28.5-style 8'hBC)
package s2p_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/s2p_deser.sv
// Serial shift history and bit-position counter.
//   i_clk    : bit clock, one serial bit per rising edge
//   i_reset  : synchronous active-high reset (clears history and counter)
//   i_clr    : synchronous clear of the bit counter (phase re-anchor)
//   i_inc    : advance the bit counter by one (wraps 7 -> 0)
//   i_data   : serial input bit, MSB of each byte first
//   o_window : {history[6:0], i_data}, the 8 most recent bits
//   o_cnt    : current bit counter value
module s2p_deser (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic       i_data,
  output logic [7:0] o_window,
  output logic [2:0] o_cnt
);

  logic [6:0] r_hist;
  logic [2:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist <= '0;
      r_cnt  <= '0;
    end else begin
      r_hist <= {r_hist[5:0], i_data};
      if (i_clr)
        r_cnt <= '0;
      else if (i_inc)
        r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_window = {r_hist, i_data};
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/s2p_comma_align.sv
// Serial-to-parallel converter with comma-based byte alignment.
//   clk_32f     : bit clock, one serial bit sampled per rising edge
//   reset       : synchronous active-high reset
//   data_in     : serial bit stream, MSB first
//   data_out    : last completed byte, held between byte boundaries
//   valid_out   : data_out is a non-comma byte received while ACTIVE
//   byte_strobe : one-cycle pulse when data_out/valid_out update
//   active_out  : high while aligned (ACTIVE)
// HUNT searches for COMMA on every bit; ALIGN checks only at byte boundaries
// and needs BC_REQ consecutive commas; ACTIVE is left only by reset.
module s2p_comma_align
  import s2p_pkg::*;
#(
  parameter logic [7:0]  COMMA  = COMMA_DEFAULT,
  parameter int unsigned BC_REQ = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active_out
);

  localparam logic [2:0] BC_LAST = 3'(BC_REQ - 1);

  state_t     r_state;
  logic [2:0] r_bc_cnt;
  logic [7:0] w_window;
  logic [2:0] w_cnt;
  logic       w_is_comma;
  logic       w_boundary;
  logic       w_clr;
  logic       w_inc;

  s2p_deser u_deser (
    .i_clk    (clk_32f),
    .i_reset  (reset),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .i_data   (data_in),
    .o_window (w_window),
    .o_cnt    (w_cnt)
  );

  // Counter is frozen in HUNT and re-anchored to 0 on the cycle a comma
  // completes, so counter==7 marks the last bit of each following byte.
  always_comb begin
    w_is_comma = (w_window == COMMA);
    w_boundary = (w_cnt == 3'd7) && (r_state != HUNT);
    w_clr      = (r_state == HUNT) && w_is_comma;
    w_inc      = (r_state != HUNT);
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state     <= HUNT;
      r_bc_cnt    <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active_out  <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_is_comma) begin
            r_bc_cnt <= 3'd1;
            r_state  <= ALIGN;
          end
        end
        ALIGN: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              if (r_bc_cnt == BC_LAST) begin
                r_state     <= ACTIVE;
                r_bc_cnt    <= '0;
                data_out    <= w_window;
                valid_out   <= 1'b0;
                byte_strobe <= 1'b1;
                active_out  <= 1'b1;
              end else begin
                r_bc_cnt <= r_bc_cnt + 3'd1;
              end
            end else begin
              r_state  <= HUNT;
              r_bc_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          if (w_boundary) begin
            data_out    <= w_window;
            valid_out   <= !w_is_comma;
            byte_strobe <= 1'b1;
          end
        end
        default: begin
          r_state  <= HUNT;
          r_bc_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_comma_align.sv
module tb_s2p_comma_align;

  localparam logic [7:0] K = 8'hBC;
  localparam int         NREQ = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active_out;

  s2p_comma_align #(.COMMA(K), .BC_REQ(NREQ)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active_out  (active_out)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Positional reference model: bits are numbered from 1 after reset;
  // lock_pos is the bit index where the last recognised comma ended.
  int         m_n;
  int         m_lock;
  int         m_commas;
  bit         m_active;
  logic [7:0] m_win;
  logic [7:0] exp_data;
  logic       exp_valid, exp_strobe, exp_active;

  task automatic model_reset();
    m_n = 0; m_lock = -1; m_commas = 0; m_active = 0; m_win = '0;
    exp_data = '0; exp_valid = 0; exp_strobe = 0; exp_active = 0;
  endtask

  task automatic model_bit(input logic b);
    m_n++;
    m_win = {m_win[6:0], b};
    exp_strobe = 0;
    if (m_active) begin
      if ((m_n - m_lock) % 8 == 0) begin
        exp_data = m_win; exp_strobe = 1; exp_valid = (m_win != K);
      end
    end else if (m_lock >= 0) begin
      if ((m_n - m_lock) % 8 == 0) begin
        if (m_win == K) begin
          m_commas++;
          if (m_commas == NREQ) begin
            m_active = 1; exp_active = 1;
            exp_data = m_win; exp_strobe = 1; exp_valid = 0;
          end
        end else begin
          m_lock = -1; m_commas = 0;
        end
      end
    end else if (m_win == K) begin
      m_lock = m_n; m_commas = 1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk_32f) begin
    if (chk_en) begin
      chk("model.data_out",    data_out,          exp_data);
      chk("model.valid_out",   {7'd0, valid_out}, {7'd0, exp_valid});
      chk("model.byte_strobe", {7'd0, byte_strobe}, {7'd0, exp_strobe});
      chk("model.active_out",  {7'd0, active_out},  {7'd0, exp_active});
    end
  end

  task automatic step(input logic b, input logic rst);
    data_in = b;
    reset   = rst;
    @(posedge clk_32f);
    #1;
    if (rst) model_reset();
    else     model_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
  endtask

  task automatic send_byte_partial(input logic [7:0] v);
    // all but the final bit, so the caller can inspect the boundary edge
    for (int i = 7; i >= 1; i--) step(v[i], 1'b0);
  endtask

  task automatic pin(input string name, input logic [7:0] d, input logic v,
                     input logic s, input logic a);
    chk({name, ".data"},   data_out,             d);
    chk({name, ".valid"},  {7'd0, valid_out},   {7'd0, v});
    chk({name, ".strobe"}, {7'd0, byte_strobe}, {7'd0, s});
    chk({name, ".active"}, {7'd0, active_out},  {7'd0, a});
  endtask

  initial begin
    logic [7:0] seq [7];
    model_reset();

    // reset held with random data
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      chk_en = 1'b1;
    end
    pin("reset", 8'h00, 0, 0, 0);

    // 3 filler bits then four commas
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(K);
    send_byte_partial(K);
    pin("pre_lock", 8'h00, 0, 0, 0);
    step(K[0], 1'b0);
    pin("lock", 8'hBC, 0, 1, 1);

    // data while active
    send_byte_partial(8'hFF); step(1'b1, 1'b0);
    pin("byteFF", 8'hFF, 1, 1, 1);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    pin("hold", 8'hFF, 1, 0, 1);
    for (int i = 5; i >= 0; i--) begin
      logic [7:0] ee;
      ee = 8'hEE;
      step(ee[i], 1'b0);
    end
    pin("byteEE", 8'hEE, 1, 1, 1);
    send_byte(K);
    pin("byteBC", 8'hBC, 0, 1, 1);
    send_byte(8'hDD);
    pin("byteDD", 8'hDD, 1, 1, 1);

    // broken comma train: realign only after 4 commas following 7C
    step(1'b0, 1'b1);
    pin("reset2", 8'h00, 0, 0, 0);
    seq = '{K, K, 8'h7C, K, K, K, K};
    for (int j = 0; j < 6; j++) send_byte(seq[j]);
    pin("after3rdBC", 8'h00, 0, 0, 0);
    send_byte(seq[6]);
    pin("after4thBC", 8'hBC, 0, 1, 1);

    // reset in the middle of byte AA while active
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    pin("midbyte_reset", 8'h00, 0, 0, 0);
    for (int j = 0; j < 3; j++) send_byte(K);
    pin("relock3", 8'h00, 0, 0, 0);
    send_byte(K);
    pin("relock4", 8'hBC, 0, 1, 1);

    // continuous 7C never locks
    step(1'b0, 1'b1);
    for (int j = 0; j < 8; j++) send_byte(8'h7C);
    pin("stream7C", 8'h00, 0, 0, 0);

    @(negedge clk_32f);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/s2p_comma_align.md
S2P_COMMA_ALIGN -- requirements
Module: s2p_comma_align

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC, the alignment/idle comma byte.
REQ-002 SHALL have parameter BC_REQ, default 4, the number of consecutive aligned commas required to go ACTIVE.
REQ-003 SHALL have port clk_32f  input  1  bit clock; one serial bit sampled per rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  1  serial bit stream, MSB of each byte first.
REQ-006 SHALL have port data_out  output  8  last completed byte, held between byte boundaries.
REQ-007 SHALL have port valid_out  output  1  data_out is a non-comma byte received while ACTIVE.
REQ-008 SHALL have port byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
REQ-009 SHALL have port active_out  output  1  high while in state ACTIVE.
REQ-010 SHALL use exactly one clock, clk_32f, and a synchronous active-high reset named reset.

Function
REQ-011 SHALL keep a 7-bit history register; window = {history[6:0], data_in} evaluated every cycle; history shifts left each cycle in every state.
REQ-012 SHALL keep a 3-bit bit counter, +1 per cycle and wrapping 7->0; byte boundary = cycle with counter==7 in ALIGN or ACTIVE.
REQ-013 SHALL implement states HUNT, ALIGN, ACTIVE, plus a 3-bit comma counter bc_cnt.
REQ-014 HUNT: every cycle window==COMMA -> counter:=0, bc_cnt:=1, ALIGN; otherwise stay, counter unchanged.
REQ-015 ALIGN, at boundary, window==COMMA: bc_cnt==BC_REQ-1 -> ACTIVE, bc_cnt:=0; otherwise bc_cnt+1.
REQ-016 ALIGN, at boundary, window!=COMMA -> HUNT, bc_cnt:=0; no comma search occurs in ALIGN between boundaries.
REQ-017 ACTIVE is left only by reset; commas and data are passed through without re-alignment.
REQ-018 SHALL update, at every boundary in ACTIVE (and on the ALIGN->ACTIVE boundary): data_out:=window, byte_strobe:=1 for one cycle, valid_out:=(window!=COMMA) && state was ACTIVE.
REQ-019 Latency: last bit of a byte sampled on edge N -> data_out/valid_out/byte_strobe visible after edge N (1 registered stage).
REQ-020 SHALL hold data_out and valid_out between boundaries; byte_strobe SHALL be low on non-boundary cycles and in HUNT/ALIGN except the transition boundary.
REQ-021 active_out SHALL be registered and rise on the same edge data_out receives the BC_REQ-th comma.
REQ-022 A comma straddling the would-be boundary in ALIGN is not recognised; the FSM falls to HUNT and re-acquires bit-wise.

Reset
REQ-023 With reset high at an edge: state:=HUNT, counter:=0, bc_cnt:=0, history:=0, data_out:=8'h00, valid_out:=0, byte_strobe:=0, active_out:=0.
REQ-024 Reset SHALL override all other events on the same edge, including mid-byte in ACTIVE; partial byte SHALL be discarded.

Structure
REQ-025 Package s2p_pkg SHALL hold the state enum (HUNT, ALIGN, ACTIVE) and the COMMA default constant 8'hBC.
REQ-026 Sub-module s2p_deser SHALL hold history register and bit counter (with sync clear input); the FSM and output registers live in s2p_comma_align.

Verification
REQ-027 Reset held 4 cycles, random data_in -> all outputs 0, active_out 0.
REQ-028 After reset, 3 random bits then BC,BC,BC,BC serial -> active_out rises 32 cycles after first BC starts, byte_strobe pulse with data_out=8'hBC, valid_out=0.
REQ-029 ACTIVE then bytes FF,EE,BC,DD -> four byte_strobe pulses 8 cycles apart; data_out FF/EE/BC/DD, valid_out 1/1/0/1.
REQ-030 BC,BC,7C,BC,BC,BC,BC -> ALIGN drops to HUNT at 7C, active_out rises only at the 4th BC after 7C.
REQ-031 Reset asserted at bit 3 of byte AA in ACTIVE -> next cycle all outputs 0, state HUNT; 4 new BC required to reach ACTIVE.
REQ-032 Continuous 8'h7C stream after reset for 64 cycles -> active_out, byte_strobe stay 0.
